seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter DW, default 8, meaning dividend and quotient width.
REQ-002 SHALL have parameter VW, default 4, meaning divisor and remainder width.
REQ-003 SHALL have port clk, input, 1 bit: the only clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-007 SHALL have port dividend, input, DW bits: unsigned numerator.
REQ-008 SHALL have port divisor, input, VW bits: unsigned denominator.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port quotient, output, DW bits: result quotient.
REQ-012 SHALL have port remainder, output, VW bits: result remainder.
REQ-013 SHALL have port dbz, output, 1 bit: divide-by-zero flag, qualified by out_valid.

Function
REQ-014 SHALL implement unsigned restoring division, one quotient bit per clock, MSB first, in the inverse role of the team's shift-add multiplier.
REQ-015 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-016 SHALL assert in_ready only in IDLE.
REQ-017 SHALL capture operands on the edge where in_valid and in_ready are both high.
REQ-018 SHALL enter CALC on capture with a nonzero divisor, clear the partial remainder, and load the iteration counter with DW-1.
REQ-019 SHALL, in each CALC cycle, shift {partial remainder, next dividend bit} left by one and subtract the divisor at VW+1 bits; a non-negative result SHALL be kept and set the quotient bit to 1, otherwise the result SHALL be discarded and the quotient bit set to 0.
REQ-020 SHALL go from CALC to DONE after the iteration with counter 0, so that out_valid rises exactly DW+1 edges after the capture edge (9 for DW=8).
REQ-021 SHALL, on capture with divisor 0, go directly to DONE with quotient all-ones, remainder 0, and dbz=1, so that out_valid rises 1 edge after capture.
REQ-022 SHALL keep dbz=0 for every nonzero divisor.
REQ-023 SHALL hold out_valid, quotient, remainder and dbz stable in DONE until out_ready is high.
REQ-024 SHALL return to IDLE on the edge where out_valid and out_ready are both high; in_ready SHALL rise in the following cycle (no same-cycle turnaround).
REQ-025 SHALL ignore in_valid and input changes outside IDLE; captured operands SHALL NOT change during CALC or DONE.
REQ-026 SHALL never produce X on any output, including on unreachable FSM encodings, which SHALL recover to IDLE.
REQ-027 SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for all nonzero divisors, including dividend 0 and dividend all-ones.

Reset
REQ-028 SHALL, while rst is high at any time including mid-CALC, force state to IDLE, in_ready to 1, out_valid to 0, and quotient, remainder, dbz and the counter to 0.
REQ-029 SHALL abort an in-flight division on reset without producing a result afterwards.
REQ-030 SHALL accept a new operand pair on the first edge after rst falls.

Structure
REQ-031 SHALL take the FSM state type, its encodings and the default widths DW and VW from a shared package seq_div_pkg.
REQ-032 SHALL place one restoring step (shift, trial subtract, select) in a combinational sub-module div_step; seq_div SHALL hold all registers and the FSM.
REQ-033 SHALL be accompanied by a golden combinational model (dividend/divisor, dividend%divisor) usable for equivalence checking against seq_div.

Verification
REQ-034 Bench SHALL check: dividend 200 (0xC8), divisor 7 -> quotient 28 (0x1C), remainder 4, dbz 0, out_valid 9 cycles after capture.
REQ-035 Bench SHALL check: dividend 255, divisor 1 -> quotient 255, remainder 0; dividend 5, divisor 15 -> quotient 0, remainder 5.
REQ-036 Bench SHALL check: dividend 0x3A, divisor 0 -> quotient 0xFF, remainder 0, dbz 1, out_valid 1 cycle after capture.
REQ-037 Bench SHALL check: out_ready held low 5 cycles in DONE -> outputs stable; in_valid pulses during CALC -> ignored.
REQ-038 Bench SHALL check: rst asserted at CALC iteration 4 -> out_valid 0 and in_ready 1 immediately; the next operands 100/9 -> quotient 11, remainder 1.
REQ-039 Bench SHALL run an exhaustive sweep of all 256x16 operand pairs with random out_ready back-pressure, with every result matching the golden model.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_div_pkg;

   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module div_step
   import seq_div_pkg::*;
#(
   parameter int VW = VW_DEF
) (
   input  logic [VW-1:0] rem_i,
   input  logic          bit_i,
   input  logic [VW-1:0] divisor_i,
   output logic [VW-1:0] rem_o,
   output logic          qbit_o
);

   logic [VW:0] shifted;

   // The shifted value is below twice the divisor, so a kept difference fits in VW bits.
   always_comb begin
      shifted = {rem_i, bit_i};
      qbit_o  = (shifted >= {1'b0, divisor_i});
      rem_o   = qbit_o ? (shifted[VW-1:0] - divisor_i) : shifted[VW-1:0];
   end

endmodule

// File: rtl/seq_div_ref.sv
// Golden combinational divider for equivalence checking against seq_div.
module seq_div_ref
   import seq_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic [DW-1:0] dividend_i,
   input  logic [VW-1:0] divisor_i,
   output logic [DW-1:0] quotient_o,
   output logic [VW-1:0] remainder_o,
   output logic          dbz_o
);

   always_comb begin
      quotient_o  = '1;
      remainder_o = '0;
      dbz_o       = 1'b1;
      if (divisor_i != '0) begin
         quotient_o  = dividend_i / DW'(divisor_i);
         remainder_o = VW'(dividend_i % DW'(divisor_i));
         dbz_o       = 1'b0;
      end
   end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dbz
);

   localparam int CW   = (DW > 1) ? $clog2(DW) : 1;
   localparam int CNTW = CW + 1;

   state_t          state_q, state_d;
   logic [DW-1:0]   dvd_q, dvd_d;
   logic [VW-1:0]   dvs_q, dvs_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [VW-1:0]   rem_q, rem_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            dbz_q, dbz_d;

   logic            step_bit;
   logic [VW-1:0]   step_rem;
   logic            step_qbit;

   assign step_bit = dvd_q[cnt_q[CW-1:0]];

   div_step #(.VW(VW)) u_step (
      .rem_i     (rem_q),
      .bit_i     (step_bit),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   // Counter runs DW-1 down past zero; its extra MSB marks the trailing cycle before DONE.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dvd_d = dividend;
               dvs_d = divisor;
               rem_d = '0;
               if (divisor == '0) begin
                  state_d = ST_DONE;
                  quo_d   = '1;
                  cnt_d   = '0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = ST_CALC;
                  quo_d   = '0;
                  cnt_d   = CNTW'(DW - 1);
                  dbz_d   = 1'b0;
               end
            end
         end
         ST_CALC: begin
            if (cnt_q[CW]) begin
               state_d = ST_DONE;
            end else begin
               rem_d = step_rem;
               quo_d = (quo_q << 1) | DW'(step_qbit);
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed and exhaustive checks of seq_div against hand-computed and arithmetic expectations.
module tb_seq_div;

   localparam int DW = 8;
   localparam int VW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          dbz;

   logic [DW-1:0] ref_dvd;
   logic [VW-1:0] ref_dvs;
   logic [DW-1:0] ref_q;
   logic [VW-1:0] ref_r;
   logic          ref_dbz;

   int n_tests;
   int n_fail;

   seq_div #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   seq_div_ref #(.DW(DW), .VW(VW)) u_ref (
      .dividend_i  (ref_dvd),
      .divisor_i   (ref_dvs),
      .quotient_o  (ref_q),
      .remainder_o (ref_r),
      .dbz_o       (ref_dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
      int g;
      g = 0;
      while (!in_ready && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      if (!in_ready) chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
   endtask

   task automatic collect(input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold,
                          input bit poke, input bit full);
      logic [DW-1:0] eq;
      logic [VW-1:0] er;
      logic          ed;
      int            lat;
      if (b == '0) begin
         eq = 8'hFF; er = 4'h0; ed = 1'b1;
      end else begin
         eq = a / {4'b0, b};
         er = 4'(a % {4'b0, b});
         ed = 1'b0;
      end
      lat = 0;
      do begin
         if (poke) begin
            in_valid = 1'b1;
            dividend = 8'hFF;
            divisor  = 4'h1;
         end
         @(posedge clk); #1;
         lat++;
         if (poke && full && lat == 1 && b != '0) chk("in_ready_busy", in_ready, 0);
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
      if (!out_valid) chk("out_valid_timeout", out_valid, 1);
      else if (full) chk("latency", lat, (b == '0) ? 1 : 9);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("dbz", dbz, ed);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_quotient", quotient, eq);
         chk("hold_remainder", remainder, er);
         chk("hold_dbz", dbz, ed);
      end
      if (!full) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (full) begin
         chk("out_valid_drop", out_valid, 0);
         chk("in_ready_back", in_ready, 1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      ref_dvd   = '0;
      ref_dvs   = '0;

      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", dbz, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      issue(8'd200, 4'd7);   collect(8'd200, 4'd7, 0, 0, 1);
      issue(8'd255, 4'd1);   collect(8'd255, 4'd1, 0, 0, 1);
      issue(8'd5, 4'd15);    collect(8'd5, 4'd15, 0, 0, 1);
      issue(8'h3A, 4'd0);    collect(8'h3A, 4'd0, 0, 0, 1);
      issue(8'd123, 4'd11);  collect(8'd123, 4'd11, 5, 1, 1);

      // Abort mid-division, then capture a fresh pair on the first edge after release.
      issue(8'd200, 4'd7);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      chk("abort_dbz", dbz, 0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b1;
      dividend = 8'd100;
      divisor  = 4'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      collect(8'd100, 4'd9, 0, 0, 1);

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            issue(8'(a), 4'(b));
            collect(8'(a), 4'(b), 0, 0, 0);
         end
      end

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            ref_dvd = 8'(a);
            ref_dvs = 4'(b);
            #1;
            chk("ref_quotient", ref_q, (b == 0) ? 32'hFF : 32'(a / b));
            chk("ref_remainder", ref_r, (b == 0) ? 32'h0 : 32'(a % b));
            chk("ref_dbz", ref_dbz, (b == 0) ? 32'h1 : 32'h0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
